// File: rtl/cmsdk_fpga_sram_dp_if.sv
// ============================================================================
// Module      : cmsdk_fpga_sram_dp_if
// Description : Bus bundle for the simple-dual-port block-RAM wrapper.
//               It carries the write port, the read port and the status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface cmsdk_fpga_sram_dp_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  // Write port
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  logic [NB-1:0] WREN;
  logic          WCS;

  // Read port
  logic [AW-1:0] RADDR;
  logic          RCS;
  logic [DW-1:0] RDATA;
  logic          RVALID;

  // Status
  logic          READY;

  modport master (
    output WADDR, WDATA, WREN, WCS, RADDR, RCS,
    input  RDATA, RVALID, READY
  );

  modport slave (
    input  WADDR, WDATA, WREN, WCS, RADDR, RCS,
    output RDATA, RVALID, READY
  );
endinterface

`default_nettype wire

// File: rtl/cmsdk_fpga_sram_dp.sv
// ============================================================================
// Module      : cmsdk_fpga_sram_dp
// Description : Simple-dual-port FPGA block-RAM wrapper. It provides one write
//               port with byte strobes and one pipelined read port with a 1- or
//               2-cycle latency and a valid flag. Address collisions can use
//               optional write-first forwarding. An optional zero-fill sweep
//               runs after reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cmsdk_fpga_sram_dp #(
  parameter int AW             = 10,
  parameter int DW             = 32,
  parameter int RLAT           = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire logic           CLK,
  input  wire logic           RESETn,
  cmsdk_fpga_sram_dp_if.slave bus
);

  localparam int            NB     = DW / 8;
  localparam int            DEPTH  = 1 << AW;
  localparam logic [AW-1:0] c_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] c_ONE  = AW'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t c_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // --------------------------------------------------------------------------
  // Storage. The array is deliberately never reset, so the tools can map it
  // onto a block-RAM primitive.
  // --------------------------------------------------------------------------
  logic [DW-1:0] r_mem [DEPTH];

  // Control state
  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic          w_clr_we;

  // Access qualification
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_collide;

  // Physical write port (shared by the sweep and user writes)
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [NB-1:0] w_wmask;

  // Read pipeline, stage 1
  logic [DW-1:0] r_ram_q;
  logic          r_v1;
  logic          r_fwd_hit;
  logic [NB-1:0] r_fwd_mask;
  logic [DW-1:0] r_fwd_data;
  logic [DW-1:0] w_s1_merge;
  logic [DW-1:0] w_s1_out;

  // --------------------------------------------------------------------------
  // Access gating. Both chip selects are ignored until READY is high. READY is
  // only high in RUN, so a user write can never collide with a sweep write.
  // --------------------------------------------------------------------------
  assign w_wr_acc  = r_ready & bus.WCS;
  assign w_rd_acc  = r_ready & bus.RCS;
  assign w_collide = w_wr_acc & w_rd_acc & (bus.WADDR == bus.RADDR);

  // FSM state register, sweep counter and registered READY
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= c_RST_STATE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // FSM next-state logic. The sweep writes address cnt on every edge and
  // hands over to RUN on the edge that writes the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we    = 1'b1;
        w_ready_nxt = 1'b0;
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
      ST_RUN: begin
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = c_RST_STATE;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write port multiplexing. The sweep drives all-zero data with every lane
  // enabled. User writes pass their own byte mask through.
  // --------------------------------------------------------------------------
  assign w_waddr = w_clr_we ? r_cnt : bus.WADDR;
  assign w_wdata = w_clr_we ? '0    : bus.WDATA;
  assign w_wmask = w_clr_we ? '1    : (w_wr_acc ? bus.WREN : '0);

  // Byte-strobed array write
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (w_wmask[b]) begin
        r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Synchronous RAM read. A same-edge write is not yet visible here, so this
  // register always holds the pre-write contents on a collision.
  always_ff @(posedge CLK) begin
    if (w_rd_acc) begin
      r_ram_q <= r_mem[bus.RADDR];
    end
  end

  // Read-valid pipeline and capture of the colliding write for forwarding.
  // The capture happens outside the RAM, so the primitive stays inferable.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_v1       <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      r_v1       <= w_rd_acc;
      r_fwd_hit  <= w_collide & (BYPASS != 0);
      r_fwd_mask <= bus.WREN;
      r_fwd_data <= bus.WDATA;
    end
  end

  // Merge forwarded lanes over the RAM output. Invalid slots are forced to 0.
  always_comb begin
    w_s1_merge = r_ram_q;
    for (int b = 0; b < NB; b++) begin
      if (r_fwd_hit && r_fwd_mask[b]) begin
        w_s1_merge[8*b +: 8] = r_fwd_data[8*b +: 8];
      end
    end
    w_s1_out = r_v1 ? w_s1_merge : '0;
  end

  // --------------------------------------------------------------------------
  // Output stage: either a direct stage-1 output or one extra register.
  // --------------------------------------------------------------------------
  generate
    if (RLAT == 2) begin : g_lat2
      logic          r_v2;
      logic [DW-1:0] r_d2;

      // Extra output register for the 2-cycle latency option
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          r_d2 <= w_s1_out;
        end
      end

      assign bus.RDATA  = r_d2;
      assign bus.RVALID = r_v2;
    end else begin : g_lat1
      assign bus.RDATA  = w_s1_out;
      assign bus.RVALID = r_v1;
    end
  endgenerate

  assign bus.READY = r_ready;

endmodule

`default_nettype wire
